// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions for the access-stage bus responders.
package tl_pkg;

  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_GET         = 3'd4;

  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } tl_resp_state_e;

  function automatic logic tl_opcode_legal(input logic [2:0] op);
    return (op == TL_PUT_FULL) || (op == TL_PUT_PARTIAL) || (op == TL_GET);
  endfunction

  // Sizes above 3 are rejected separately, so they report aligned here.
  function automatic logic tl_misaligned(input logic [63:0] addr, input logic [2:0] size);
    logic mis;
    mis = 1'b0;
    case (size)
      3'd1:    mis = addr[0];
      3'd2:    mis = |addr[1:0];
      3'd3:    mis = |addr[2:0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/tl_mem_array.sv
// Byte-enable 64-bit RAM, single shared address, synchronous read and write.
module tl_mem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wmask,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem_q [DEPTH];
  logic [63:0] rdata_q;

  // The read samples the array before this edge's write lands, so a
  // same-edge read returns the old word; rdata holds until the next read.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (wmask[i]) begin
          mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/tl_mem_responder.sv
// TileLink-UL channel A/D responder backed by a local RAM, one request at a time.
module tl_mem_responder
  import tl_pkg::*;
#(
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2,
  parameter int          SRC_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [2:0]       a_opcode,
  input  logic [2:0]       a_param,
  input  logic [2:0]       a_size,
  input  logic [SRC_W-1:0] a_source,
  input  logic [63:0]      a_address,
  input  logic [7:0]       a_mask,
  input  logic [63:0]      a_data,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [2:0]       d_opcode,
  output logic [1:0]       d_param,
  output logic [2:0]       d_size,
  output logic [SRC_W-1:0] d_source,
  output logic             d_denied,
  output logic [63:0]      d_data
);

  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [63:0] LIMIT    = BASE + 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  tl_resp_state_e   state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       d_opcode_q, d_opcode_d;
  logic [2:0]       d_size_q, d_size_d;
  logic [SRC_W-1:0] d_source_q, d_source_d;
  logic             d_denied_q, d_denied_d;
  logic             data_sel_q, data_sel_d;

  logic [63:0]      offset;
  logic             denied;
  logic             is_get;
  logic             is_put;
  logic             accept;
  logic             mem_we;
  logic             mem_re;
  logic [63:0]      mem_rdata;
  logic             unused_bits;

  assign offset = a_address - BASE;
  assign is_get = (a_opcode == TL_GET);
  assign is_put = (a_opcode == TL_PUT_FULL) || (a_opcode == TL_PUT_PARTIAL);
  assign accept = a_valid && (state_q == IDLE);

  always_comb begin
    denied = (a_address < BASE) || (a_address >= LIMIT) || (a_size > 3'd3)
          || tl_misaligned(a_address, a_size) || !tl_opcode_legal(a_opcode);
  end

  assign mem_we = accept && is_put && !denied;
  assign mem_re = accept && is_get && !denied;

  tl_mem_array #(
    .DEPTH(DEPTH),
    .AW   (IDX_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (offset[3 +: IDX_W]),
    .wmask(a_mask),
    .wdata(a_data),
    .rdata(mem_rdata)
  );

  // Response fields are captured at the accept edge and held through RESP;
  // the read word itself sits in the array's output register meanwhile.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    d_opcode_d = d_opcode_q;
    d_size_d   = d_size_q;
    d_source_d = d_source_q;
    d_denied_d = d_denied_q;
    data_sel_d = data_sel_q;
    unique case (state_q)
      IDLE: begin
        if (a_valid) begin
          d_opcode_d = is_get ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
          d_size_d   = a_size;
          d_source_d = a_source;
          d_denied_d = denied;
          data_sel_d = is_get && !denied;
          cnt_d      = LAT_LOAD;
          state_d    = (LATENCY > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (d_ready) begin
          state_d    = IDLE;
          data_sel_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      d_opcode_q <= 3'd0;
      d_size_q   <= 3'd0;
      d_source_q <= '0;
      d_denied_q <= 1'b0;
      data_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d_opcode_q <= d_opcode_d;
      d_size_q   <= d_size_d;
      d_source_q <= d_source_d;
      d_denied_q <= d_denied_d;
      data_sel_q <= data_sel_d;
    end
  end

  assign a_ready  = (state_q == IDLE);
  assign d_valid  = (state_q == RESP);
  assign d_opcode = d_opcode_q;
  assign d_param  = 2'd0;
  assign d_size   = d_size_q;
  assign d_source = d_source_q;
  assign d_denied = d_denied_q;
  assign d_data   = data_sel_q ? mem_rdata : 64'd0;

  assign unused_bits = ^{a_param, offset[63:IDX_W+3], offset[2:0]};

endmodule

// File: tb/tb_tl_mem_responder.sv
// Self-checking bench: two responders (LATENCY=2 and LATENCY=0) against a transaction-level model.
module tb_tl_mem_responder;
  import tl_pkg::*;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          SRC_W = 4;

  logic             clk;
  logic             rst_n;
  logic             a_valid   [2];
  logic             a_ready   [2];
  logic [2:0]       a_opcode  [2];
  logic [2:0]       a_param   [2];
  logic [2:0]       a_size    [2];
  logic [SRC_W-1:0] a_source  [2];
  logic [63:0]      a_address [2];
  logic [7:0]       a_mask    [2];
  logic [63:0]      a_data    [2];
  logic             d_valid   [2];
  logic             d_ready   [2];
  logic [2:0]       d_opcode  [2];
  logic [1:0]       d_param   [2];
  logic [2:0]       d_size    [2];
  logic [SRC_W-1:0] d_source  [2];
  logic             d_denied  [2];
  logic [63:0]      d_data    [2];

  int checks   = 0;
  int failures = 0;
  bit checking = 0;

  tl_mem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(2), .SRC_W(SRC_W)) u_dut_lat2 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid[0]), .a_ready(a_ready[0]), .a_opcode(a_opcode[0]), .a_param(a_param[0]),
    .a_size(a_size[0]), .a_source(a_source[0]), .a_address(a_address[0]), .a_mask(a_mask[0]),
    .a_data(a_data[0]), .d_valid(d_valid[0]), .d_ready(d_ready[0]), .d_opcode(d_opcode[0]),
    .d_param(d_param[0]), .d_size(d_size[0]), .d_source(d_source[0]), .d_denied(d_denied[0]),
    .d_data(d_data[0])
  );

  tl_mem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(0), .SRC_W(SRC_W)) u_dut_lat0 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid[1]), .a_ready(a_ready[1]), .a_opcode(a_opcode[1]), .a_param(a_param[1]),
    .a_size(a_size[1]), .a_source(a_source[1]), .a_address(a_address[1]), .a_mask(a_mask[1]),
    .a_data(a_data[1]), .d_valid(d_valid[1]), .d_ready(d_ready[1]), .d_opcode(d_opcode[1]),
    .d_param(d_param[1]), .d_size(d_size[1]), .d_source(d_source[1]), .d_denied(d_denied[1]),
    .d_data(d_data[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Model state: a pending response is due a fixed number of cycles after accept.
  int          cyc = 0;
  bit          busy_m   [2];
  int          due_m    [2];
  logic [2:0]  e_op     [2];
  logic [2:0]  e_size   [2];
  logic [3:0]  e_src    [2];
  logic        e_den    [2];
  logic [63:0] e_data   [2];
  bit          e_known  [2];
  logic [63:0] mem_m    [2][DEPTH];
  bit   [7:0]  known_m  [2][DEPTH];

  task automatic modelAccept(input int i);
    logic [63:0] addr;
    bit den;
    bit get;
    int w;
    addr = a_address[i];
    get  = (a_opcode[i] == 3'd4);
    den  = 0;
    if (addr < BASE || addr >= BASE + 64'(DEPTH) * 64'd8) den = 1;
    if (a_size[i] > 3'd3) den = 1;
    else if ((addr % (64'd1 << a_size[i])) != 64'd0) den = 1;
    if (!(a_opcode[i] == 3'd0 || a_opcode[i] == 3'd1 || a_opcode[i] == 3'd4)) den = 1;
    w = den ? 0 : int'((addr - BASE) / 64'd8);
    e_op[i]    = get ? 3'd1 : 3'd0;
    e_size[i]  = a_size[i];
    e_src[i]   = a_source[i];
    e_den[i]   = den;
    e_data[i]  = 64'd0;
    e_known[i] = 1;
    if (!den && get) begin
      e_data[i]  = mem_m[i][w];
      e_known[i] = (known_m[i][w] == 8'hFF);
    end else if (!den) begin
      for (int b = 0; b < 8; b++) begin
        if (a_mask[i][b]) begin
          mem_m[i][w][8*b +: 8] = a_data[i][8*b +: 8];
          known_m[i][w][b] = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_m[0] = 0;
      busy_m[1] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (busy_m[i]) begin
          if (cyc >= due_m[i] && d_ready[i]) busy_m[i] = 0;
        end else if (a_valid[i]) begin
          modelAccept(i);
          busy_m[i] = 1;
          due_m[i]  = cyc + 1 + lat_of(i);
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        bit dv;
        dv = busy_m[i] && (cyc >= due_m[i]);
        checkOutput($sformatf("a_ready[%0d]", i), 64'(a_ready[i]), 64'(!busy_m[i]));
        checkOutput($sformatf("d_valid[%0d]", i), 64'(d_valid[i]), 64'(dv));
        if (dv) begin
          checkOutput($sformatf("d_opcode[%0d]", i), 64'(d_opcode[i]), 64'(e_op[i]));
          checkOutput($sformatf("d_param[%0d]", i), 64'(d_param[i]), 64'd0);
          checkOutput($sformatf("d_size[%0d]", i), 64'(d_size[i]), 64'(e_size[i]));
          checkOutput($sformatf("d_source[%0d]", i), 64'(d_source[i]), 64'(e_src[i]));
          checkOutput($sformatf("d_denied[%0d]", i), 64'(d_denied[i]), 64'(e_den[i]));
          if (e_known[i]) checkOutput($sformatf("d_data[%0d]", i), d_data[i], e_data[i]);
        end
      end
    end
  end

  task automatic applyStimulus(input int idx, input logic [2:0] op, input logic [2:0] size,
                               input logic [3:0] src, input logic [63:0] addr,
                               input logic [7:0] mask, input logic [63:0] data, input int stall,
                               output logic [2:0] r_op, output logic r_den,
                               output logic [63:0] r_data, output logic [2:0] r_size,
                               output logic [3:0] r_src, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!a_ready[idx] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("a_ready_timeout", 64'(a_ready[idx]), 64'd1);
    a_valid[idx]   = 1'b1;
    a_opcode[idx]  = op;
    a_size[idx]    = size;
    a_source[idx]  = src;
    a_address[idx] = addr;
    a_mask[idx]    = mask;
    a_data[idx]    = data;
    d_ready[idx]   = (stall == 0);
    @(negedge clk);
    a_valid[idx] = 1'b0;
    lat = 1;
    while (!d_valid[idx] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    r_op   = d_opcode[idx];
    r_den  = d_denied[idx];
    r_data = d_data[idx];
    r_size = d_size[idx];
    r_src  = d_source[idx];
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      d_ready[idx] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic runTxn(input string name, input int idx, input logic [2:0] op,
                        input logic [2:0] size, input logic [3:0] src, input logic [63:0] addr,
                        input logic [7:0] mask, input logic [63:0] data, input int stall,
                        input logic [2:0] x_op, input logic x_den, input bit chk_data,
                        input logic [63:0] x_data, input int x_lat);
    logic [2:0]  r_op;
    logic        r_den;
    logic [63:0] r_data;
    logic [2:0]  r_size;
    logic [3:0]  r_src;
    int          lat;
    applyStimulus(idx, op, size, src, addr, mask, data, stall, r_op, r_den, r_data, r_size, r_src, lat);
    checkOutput({name, "_lat"}, 64'(lat), 64'(x_lat));
    checkOutput({name, "_op"}, 64'(r_op), 64'(x_op));
    checkOutput({name, "_denied"}, 64'(r_den), 64'(x_den));
    if (chk_data) checkOutput({name, "_data"}, r_data, x_data);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  r_op;
    logic        r_den;
    logic [63:0] r_data;
    logic [2:0]  r_size;
    logic [3:0]  r_src;
    int          lat;
    for (int i = 0; i < 2; i++) begin
      a_valid[i] = 0; a_opcode[i] = 0; a_param[i] = 0; a_size[i] = 0; a_source[i] = 0;
      a_address[i] = 0; a_mask[i] = 0; a_data[i] = 0; d_ready[i] = 1;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("rst_a_ready[%0d]", i), 64'(a_ready[i]), 64'd1);
      checkOutput($sformatf("rst_d_valid[%0d]", i), 64'(d_valid[i]), 64'd0);
      checkOutput($sformatf("rst_d_denied[%0d]", i), 64'(d_denied[i]), 64'd0);
      checkOutput($sformatf("rst_d_data[%0d]", i), d_data[i], 64'd0);
      checkOutput($sformatf("rst_d_fields[%0d]", i),
                  64'({d_opcode[i], d_param[i], d_size[i], d_source[i]}), 64'd0);
    end
    #2 rst_n = 1'b1;
    checking = 1;

    // LATENCY=2 instance
    runTxn("put_full", 0, TL_PUT_FULL, 3, 1, 64'h8000_0010, 8'hFF, 64'h1122334455667788, 0,
           3'd0, 0, 1, 64'd0, 3);
    runTxn("get_full", 0, TL_GET, 3, 2, 64'h8000_0010, 8'hFF, 64'd0, 0,
           3'd1, 0, 1, 64'h1122334455667788, 3);
    runTxn("put_zero", 0, TL_PUT_FULL, 3, 0, 64'h8000_0018, 8'hFF, 64'd0, 0, 3'd0, 0, 1, 64'd0, 3);
    runTxn("put_part", 0, TL_PUT_PARTIAL, 3, 0, 64'h8000_0018, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 0,
           3'd0, 0, 1, 64'd0, 3);
    runTxn("get_part", 0, TL_GET, 3, 0, 64'h8000_0018, 8'hFF, 64'd0, 0,
           3'd1, 0, 1, 64'h0000_0000_FFFF_FFFF, 3);
    runTxn("get_oor", 0, TL_GET, 3, 3, 64'h8000_2000, 8'hFF, 64'd0, 0, 3'd1, 1, 1, 64'd0, 3);
    runTxn("put_top", 0, TL_PUT_FULL, 3, 0, 64'h8000_1FF8, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0, 0,
           3'd0, 0, 1, 64'd0, 3);
    runTxn("put_below", 0, TL_PUT_FULL, 3, 0, 64'h7FFF_FFF8, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD, 0,
           3'd0, 1, 1, 64'd0, 3);
    runTxn("get_top", 0, TL_GET, 3, 0, 64'h8000_1FF8, 8'hFF, 64'd0, 0,
           3'd1, 0, 1, 64'hA5A5_5A5A_0F0F_F0F0, 3);
    runTxn("bad_opcode", 0, 3'd2, 3, 0, 64'h8000_0010, 8'hFF, 64'd0, 0, 3'd0, 1, 1, 64'd0, 3);
    runTxn("bad_size", 0, TL_GET, 3'd4, 0, 64'h8000_0010, 8'hFF, 64'd0, 0, 3'd1, 1, 1, 64'd0, 3);
    runTxn("stall_get", 0, TL_GET, 3, 7, 64'h8000_0010, 8'hFF, 64'd0, 5,
           3'd1, 0, 1, 64'h1122334455667788, 3);
    checkOutput("stall_a_ready_after", 64'(a_ready[0]), 64'd1);

    // Reset while the LATENCY=2 instance is waiting; the write must survive.
    @(negedge clk);
    a_valid[0] = 1; a_opcode[0] = TL_PUT_FULL; a_size[0] = 3; a_source[0] = 4'd9;
    a_address[0] = 64'h8000_0020; a_mask[0] = 8'hFF; a_data[0] = 64'hCAFE_F00D_1234_5678;
    @(negedge clk);
    a_valid[0] = 0;
    checkOutput("wait_a_ready", 64'(a_ready[0]), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_wait_a_ready", 64'(a_ready[0]), 64'd1);
    checkOutput("rst_wait_d_valid", 64'(d_valid[0]), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      #1 checkOutput("post_rst_no_resp", 64'(d_valid[0]), 64'd0);
    end
    runTxn("get_after_rst", 0, TL_GET, 3, 0, 64'h8000_0020, 8'hFF, 64'd0, 0,
           3'd1, 0, 1, 64'hCAFE_F00D_1234_5678, 3);

    // LATENCY=0 instance
    runTxn("l0_put", 1, TL_PUT_FULL, 3, 0, 64'h8000_0000, 8'hFF, 64'h0123_4567_89AB_CDEF, 0,
           3'd0, 0, 1, 64'd0, 1);
    applyStimulus(1, TL_GET, 3'd2, 4'd5, 64'h8000_0004, 8'hF0, 64'd0, 0,
                  r_op, r_den, r_data, r_size, r_src, lat);
    checkOutput("l0_get_lat", 64'(lat), 64'd1);
    checkOutput("l0_get_source", 64'(r_src), 64'd5);
    checkOutput("l0_get_size", 64'(r_size), 64'd2);
    checkOutput("l0_get_denied", 64'(r_den), 64'd0);
    checkOutput("l0_get_data", r_data, 64'h0123_4567_89AB_CDEF);
    runTxn("l0_misalign", 1, TL_GET, 3, 2, 64'h8000_0004, 8'hFF, 64'd0, 0,
           3'd1, 1, 1, 64'd0, 1);
    runTxn("l0_last_word", 1, TL_GET, 3, 1, 64'h8000_1FF8, 8'hFF, 64'd0, 0,
           3'd1, 0, 0, 64'd0, 1);

    repeat (3) @(negedge clk);
    checking = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
